// File: rtl/sm_reg_snapshot.sv
// sm_reg_snapshot: walks all 32 cpu debug registers through the debug read
// port and copies them into a 32x32 shadow buffer. The display reads the
// shadow through a registered port, so it always sees a stable image that is
// independent of the divided cpu clock.
//
// Each register takes SETTLE+2 cycles: one ADDR cycle to drive regAddr,
// SETTLE WAIT cycles so the cpu-side mux can settle, and one CAPTURE cycle.
//
// Optional feature (macro SM_REG_SNAPSHOT_CHANGE_EN): per-register "changed
// since previous snapshot" mask. Without the macro the changed port reads 0
// and no comparators are built.
module sm_reg_snapshot #(
  parameter int unsigned SETTLE = 2   // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  input  logic [4:0]  rdAddr,
  output logic [31:0] rdData,
  output logic        busy,
  output logic        done,
  output logic [31:0] changed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  // WAIT runs while wcnt counts down to zero, giving SETTLE cycles in WAIT
  localparam logic [3:0] WLOAD = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        cap_en;
  logic [31:0] shadow_q [32];
  logic [31:0] rdData_q;

  // Next-state and Moore outputs; start is only looked at in IDLE, so a
  // request during a snapshot (or in DONE) is dropped rather than queued
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    cap_en  = 1'b0;
    regAddr = 5'd0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          idx_d   = 5'd0;
        end
      end
      S_ADDR: begin
        regAddr = idx_q;
        busy    = 1'b1;
        wcnt_d  = WLOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        regAddr = idx_q;
        busy    = 1'b1;
        if (wcnt_q == 4'd0) state_d = S_CAPTURE;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      S_CAPTURE: begin
        regAddr = idx_q;
        busy    = 1'b1;
        cap_en  = 1'b1;
        if (idx_q == 5'd31) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_ADDR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd0;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Shadow buffer; reset wipes it so an aborted snapshot leaves no partial image
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if (cap_en) begin
      shadow_q[idx_q] <= regData;
    end
  end

  // Registered display read; sees the pre-write word when it collides with a capture
  always_ff @(posedge clk) begin
    if (rst) rdData_q <= '0;
    else     rdData_q <= shadow_q[rdAddr];
  end

  assign rdData = rdData_q;

`ifdef SM_REG_SNAPSHOT_CHANGE_EN
  logic [31:0] changed_q;

  // Change mask: a bit is rewritten only when its register is captured
  always_ff @(posedge clk) begin
    if (rst)         changed_q        <= '0;
    else if (cap_en) changed_q[idx_q] <= (regData != shadow_q[idx_q]);
  end

  assign changed = changed_q;
`else
  assign changed = 32'h0;
`endif

endmodule

// File: doc/sm_reg_snapshot.md
SM_REG_SNAPSHOT -- requirements
Module: sm_reg_snapshot

Interface
REQ-001 Parameter SETTLE, default 2: cycles regAddr is held before regData is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock (clkIn domain); all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  snapshot request (e.g. vsync edge); sampled only in IDLE.
REQ-005 regAddr  output  5  register index driven to the cpu debug read port.
REQ-006 regData  input  32  cpu register value for regAddr; combinational from the cpu side.
REQ-007 rdAddr  input  5  display-side read index from vga_debug_screen.
REQ-008 rdData  output  32  shadow[rdAddr], registered.
REQ-009 busy  output  1  high while a snapshot is in progress.
REQ-010 done  output  1  one-cycle pulse at snapshot completion.
REQ-011 changed  output  32  per-register changed-since-previous-snapshot mask.

Function
REQ-012 Block SHALL hold a 32x32 shadow buffer giving the display a stable register image, decoupled from the divided cpu clock.
REQ-013 FSM states SHALL be IDLE, ADDR, WAIT, CAPTURE, DONE, with index counter idx[4:0] and settle counter wcnt[3:0].
REQ-014 IDLE: start=1 -> ADDR with idx=0; start=0 -> stay; regAddr=0.
REQ-015 ADDR: regAddr=idx; load wcnt=SETTLE-1; -> WAIT.
REQ-016 WAIT: regAddr=idx; wcnt==0 -> CAPTURE, else wcnt decrements.
REQ-017 CAPTURE: shadow[idx] <= regData; idx==31 -> DONE; else idx increments -> ADDR.
REQ-018 DONE: done=1 for exactly this cycle; -> IDLE unconditionally.
REQ-019 regAddr SHALL equal idx in ADDR/WAIT/CAPTURE and 0 in IDLE/DONE.
REQ-020 busy SHALL be 1 in ADDR, WAIT, CAPTURE only; 0 in IDLE and DONE.
REQ-021 Per-register time SHALL be SETTLE+2 cycles; start accepted at edge N -> done high during the cycle after edge N+32*(SETTLE+2).
REQ-022 start while not IDLE (including DONE) SHALL be ignored, not queued.
REQ-023 start held high continuously SHALL produce back-to-back snapshots, one IDLE cycle between DONE and next ADDR.
REQ-024 rdData SHALL be registered: rdData at edge k+1 = shadow[rdAddr sampled at edge k].
REQ-025 Read and CAPTURE write to same index in same cycle SHALL return the old value (read-before-write).
REQ-026 regData SHALL be captured unmodified at full 32-bit width; no arithmetic on data.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, idx=0, wcnt=0, regAddr=0, busy=0, done=0, rdData=0, changed=0, all shadow words=0.
REQ-028 rst asserted mid-snapshot SHALL abort it with no done pulse; partial captures are cleared.
REQ-029 rst SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro SM_REG_SNAPSHOT_CHANGE_EN compiles in change tracking.
REQ-031 With the macro: in CAPTURE, changed[idx] <= (regData != shadow[idx]); other bits hold; reset clears all bits.
REQ-032 Without the macro: changed port remains present, tied to 32'h0, no comparison logic built.

Verification
REQ-033 Reset, then regData model returns 32'hA000_0000+addr, SETTLE=2, pulse start -> done exactly 128 cycles after ADDR entry; rdAddr=5 gives rdData=32'hA000_0005 one cycle later.
REQ-034 Model changes register 3 only between two snapshots -> with macro changed=32'h0000_0008 after second done; without macro changed=0.
REQ-035 Pulse start at cycle 40 of a running snapshot -> no restart, single done pulse, idx sequence 0..31 monotonic.
REQ-036 Assert rst at idx=17 -> next cycle busy=0, regAddr=0, all rdAddr reads return 0, no done pulse.
REQ-037 SETTLE=1 and SETTLE=15 -> regAddr stable for SETTLE+2 cycles per index, done after 96 and 544 busy cycles respectively.
REQ-038 rdAddr=31 during CAPTURE of idx 31 -> rdData old value that cycle, new value on next read.
